// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Purpose  : Shared TMDS control tokens, alignment state type, offset helper.
// Revision : 1.0  initial release
// ============================================================================
package tmds_pkg;

  localparam int c_word_w = 10;

  localparam logic [c_word_w-1:0] c_tok_ctl0 = 10'b1101010100;
  localparam logic [c_word_w-1:0] c_tok_ctl1 = 10'b0010101011;
  localparam logic [c_word_w-1:0] c_tok_ctl2 = 10'b0101010100;
  localparam logic [c_word_w-1:0] c_tok_ctl3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  // Bit-slip offsets run 0..9 and wrap.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off >= 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_word_decode.sv
`default_nettype none
// ============================================================================
// Module   : tmds_word_decode
// Purpose  : Combinational 10b TMDS word to {ve, data, control} decoder.
// Revision : 1.0  initial release
// ============================================================================
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [c_word_w-1:0] i_word,
  output logic                o_ve,
  output logic [7:0]          o_data,
  output logic [1:0]          o_control
);

  logic [7:0] w_q;

  always_comb begin
    w_q       = i_word[7:0] ^ {8{i_word[9]}};
    o_data    = '0;
    o_data[0] = w_q[0];
    // q[8] selects XOR (1) or XNOR (0) chaining of adjacent bits.
    for (int i = 1; i < 8; i++) begin
      o_data[i] = w_q[i] ^ w_q[i-1] ^ ~i_word[8];
    end

    o_ve      = 1'b1;
    o_control = 2'b00;
    case (i_word)
      c_tok_ctl0: begin o_ve = 1'b0; o_control = 2'b00; end
      c_tok_ctl1: begin o_ve = 1'b0; o_control = 2'b01; end
      c_tok_ctl2: begin o_ve = 1'b0; o_control = 2'b10; end
      c_tok_ctl3: begin o_ve = 1'b0; o_control = 2'b11; end
      default:    ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder
// Purpose  : TMDS receive channel: word alignment by control-token runs,
//            then per-word decode. TMDS_DECODER_ERRCNT_EN adds a lock-loss
//            counter on err_count_out.
// Revision : 1.0  initial release
// ============================================================================
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [c_word_w-1:0] tmds_in,
  output logic [7:0]          data_out,
  output logic [1:0]          control_out,
  output logic                ve_out,
  output logic                locked_out,
  output logic [3:0]          offset_out,
  output logic [15:0]         err_count_out
);

  localparam int c_win_max = (SEARCH_WINDOW > LOCK_TIMEOUT) ? SEARCH_WINDOW : LOCK_TIMEOUT;
  localparam int c_win_w   = $clog2(c_win_max) + 1;
  localparam int c_run_w   = $clog2(TOKEN_RUN + 1);

  logic [2*c_word_w-1:0] r_hist;
  logic [c_word_w-1:0]   w_word;
  logic                  w_ve;
  logic [7:0]            w_data;
  logic [1:0]            w_control;
  logic                  r_tok;

  align_state_e          r_state, w_state_nxt;
  logic [3:0]            r_offset, w_offset_nxt;
  logic [c_run_w-1:0]    r_run_cnt, w_run_nxt;
  logic [c_win_w-1:0]    r_win_cnt, w_win_nxt, w_limit;
  logic                  w_run_done;
  logic                  r_locked;

  assign w_word = c_word_w'(r_hist >> r_offset);

  tmds_word_decode u_word_decode (
    .i_word    (w_word),
    .o_ve      (w_ve),
    .o_data    (w_data),
    .o_control (w_control)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hist      <= '0;
      data_out    <= '0;
      control_out <= '0;
      ve_out      <= 1'b0;
      r_tok       <= 1'b0;
    end else begin
      r_hist      <= {tmds_in, r_hist[2*c_word_w-1:c_word_w]};
      data_out    <= w_data;
      control_out <= w_control;
      ve_out      <= w_ve;
      r_tok       <= ~w_ve;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= SEARCH;
      r_offset  <= '0;
      r_run_cnt <= '0;
      r_win_cnt <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_offset  <= w_offset_nxt;
      r_run_cnt <= w_run_nxt;
      r_win_cnt <= w_win_nxt;
      r_locked  <= (w_state_nxt == LOCKED);
    end
  end

  // Run detection works on the output stage, so a completed run always wins
  // over a timeout in the same cycle.
  always_comb begin
    w_run_done   = r_tok && (r_run_cnt == c_run_w'(TOKEN_RUN - 1));
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_win_nxt    = r_win_cnt + 1'b1;
    w_limit      = (r_state == SEARCH) ? c_win_w'(SEARCH_WINDOW - 1)
                                       : c_win_w'(LOCK_TIMEOUT - 1);
    if (!r_tok) begin
      w_run_nxt = '0;
    end else if (r_run_cnt >= c_run_w'(TOKEN_RUN)) begin
      w_run_nxt = r_run_cnt;
    end else begin
      w_run_nxt = r_run_cnt + 1'b1;
    end

    case (r_state)
      SEARCH, VERIFY, LOCKED: begin
        if (w_run_done) begin
          w_win_nxt = '0;
          if (r_state == SEARCH) begin
            w_state_nxt = VERIFY;
          end else begin
            w_state_nxt = LOCKED;
          end
        end else if (r_win_cnt == w_limit) begin
          w_state_nxt  = SEARCH;
          w_offset_nxt = next_offset(r_offset);
          w_win_nxt    = '0;
          w_run_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_win_nxt   = '0;
        w_run_nxt   = '0;
      end
    endcase
  end

  assign locked_out = r_locked;
  assign offset_out = r_offset;

`ifdef TMDS_DECODER_ERRCNT_EN
  logic        w_lost;
  logic [15:0] r_err_cnt;

  assign w_lost = (r_state == LOCKED) && (w_state_nxt == SEARCH);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_err_cnt <= '0;
    end else if (w_lost && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count_out = r_err_cnt;
`else
  assign err_count_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_decoder
// Purpose  : Self-checking bench for tmds_decoder against a stream-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tmds_decoder;

  localparam int TR   = 8;
  localparam int SW   = 2048;
  localparam int LT   = 4096;
  localparam int LINE = 1650;
  localparam int NTOK = 370;

`ifdef TMDS_DECODER_ERRCNT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        clk_pixel = 1'b0;
  logic        rst       = 1'b0;
  logic [9:0]  tmds      = '0;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        ve;
  logic        locked;
  logic [3:0]  offset;
  logic [15:0] err_cnt;

  always #5 clk_pixel = ~clk_pixel;

  tmds_decoder #(
    .TOKEN_RUN     (TR),
    .SEARCH_WINDOW (SW),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .clk_in        (clk_pixel),
    .rst_in        (rst),
    .tmds_in       (tmds),
    .data_out      (data),
    .control_out   (ctrl),
    .ve_out        (ve),
    .locked_out    (locked),
    .offset_out    (offset),
    .err_count_out (err_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] log_w [0:32767];
  int         n;
  int         enc_cnt;
  logic [9:0] prev_w;

  // Model state: 0 search, 1 verify, 2 locked
  int         m_state, m_off, m_run, m_timer, m_err;
  bit         m_tok, m_ve;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n, act, exp);
  endtask

  function automatic logic [9:0] get_w(input int j);
    if (j < 0) return 10'd0;
    return log_w[j];
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] q, d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic int ref_token(input logic [9:0] w);
    case (w)
      T00:     return 0;
      T01:     return 1;
      T10:     return 2;
      T11:     return 3;
      default: return -1;
    endcase
  endfunction

  // DVI reference encoder with running disparity
  function automatic logic [9:0] tmds_encode(input logic [7:0] d);
    int n1, n1q, n0q;
    logic [8:0] qm;
    logic [9:0] q;
    n1    = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -(qm[8] ? 0 : 2) + n1q - n0q;
    end
    return q;
  endfunction

  task automatic model_reset();
    m_state = 0; m_off = 0; m_run = 0; m_timer = 0; m_err = 0;
    m_tok = 0; m_ve = 0; m_data = '0; m_ctrl = '0;
    n = 0;
  endtask

  // Advance the model by one clock edge with index n.
  task automatic model_edge();
    int k_prev, t;
    bit tok, done;
    logic [19:0] pair;
    logic [9:0]  win;
    k_prev = m_off;
    tok    = m_tok;
    done   = 0;
    if (tok) begin
      if (m_run == TR - 1) done = 1;
      if (m_run < TR) m_run++;
    end else begin
      m_run = 0;
    end
    if (done) begin
      m_state = (m_state == 0) ? 1 : 2;
      m_timer = 0;
    end else if (m_timer == ((m_state == 0) ? SW : LT) - 1) begin
      if (m_state == 2 && m_err < 65535) m_err += EXP_ERR;
      m_state = 0;
      m_off   = (m_off + 1) % 10;
      m_timer = 0;
      m_run   = 0;
    end else begin
      m_timer++;
    end
    pair   = {get_w(n - 1), get_w(n - 2)};
    win    = 10'(pair >> k_prev);
    t      = ref_token(win);
    m_ve   = (t < 0);
    m_tok  = !m_ve;
    m_ctrl = (t < 0) ? 2'b00 : 2'(t);
    m_data = ref_decode(win);
  endtask

  task automatic step(input logic [9:0] w);
    tmds     = w;
    log_w[n] = w;
    @(posedge clk_pixel);
    #1;
    model_edge();
    chk("ve", 32'(ve), 32'(m_ve));
    if (m_ve) chk("data", 32'(data), 32'(m_data));
    else      chk("control", 32'(ctrl), 32'(m_ctrl));
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("offset", 32'(offset), 32'(m_off));
    chk("err_count", 32'(err_cnt), 32'(m_err));
    n++;
  endtask

  // One word of the standard line, delayed by skew bits in the serial stream.
  task automatic feed(input int skew, input int pos);
    logic [9:0] w;
    if (pos < NTOK) w = T00;
    else            w = tmds_encode(8'((pos - NTOK) % 256));
    step(10'({w, prev_w} >> (10 - skew)));
    prev_w = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_control", 32'(ctrl), 32'd0);
    chk("rst_ve", 32'(ve), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    tmds = '0;
    @(posedge clk_pixel);
    #1;
    model_reset();
    enc_cnt = 0;
    prev_w  = '0;
    @(negedge clk_pixel);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] ctl_seq [0:5];
    bit seen_lock;

    #2;
    // Aligned stream, control decode, then lock loss
    do_reset();
    for (int i = 0; i < 4 * LINE; i++) begin
      feed(0, i % LINE);
      if (i == 372)  chk("first_byte", 32'(data), 32'h00);
      if (i == 373)  chk("second_byte", 32'(data), 32'h01);
      if (i == 1659) chk("pre_lock", 32'(locked), 32'd0);
      if (i == 1660) chk("lock_after_second_run", 32'(locked), 32'd1);
    end
    chk("aligned_offset", 32'(offset), 32'd0);

    ctl_seq[0] = T00; ctl_seq[1] = T01; ctl_seq[2] = T10; ctl_seq[3] = T11;
    ctl_seq[4] = 10'h100; ctl_seq[5] = 10'h100;
    for (int i = 0; i < 6; i++) begin
      step(ctl_seq[i]);
      if (i >= 2) begin
        chk("ctl_ve", 32'(ve), 32'd0);
        chk("ctl_symbol", 32'(ctrl), 32'(i - 2));
      end
    end

    chk("locked_before_timeout", 32'(locked), 32'd1);
    for (int i = 0; i < LT; i++) step(tmds_encode(8'(i % 256)));
    chk("timeout_unlocked", 32'(locked), 32'd0);
    chk("timeout_offset", 32'(offset), 32'd1);
    chk("timeout_err", 32'(err_cnt), 32'(EXP_ERR));

    // Stream skewed by 3 bits
    do_reset();
    for (int i = 0; i < 8 * LINE; i++) begin
      feed(3, i % LINE);
      if (i == SW - 2)     chk("skew_off0", 32'(offset), 32'd0);
      if (i == SW - 1)     chk("skew_off1", 32'(offset), 32'd1);
      if (i == 2 * SW - 1) chk("skew_off2", 32'(offset), 32'd2);
      if (i == 3 * SW - 1) chk("skew_off3", 32'(offset), 32'd3);
    end
    chk("skew_locked", 32'(locked), 32'd1);
    chk("skew_offset", 32'(offset), 32'd3);

    // Runs of 7 tokens never lock; offset walks 0..9 and wraps
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 10 * SW + 50; i++) begin
      step(((i % 37) < 7) ? T00 : 10'h100);
      seen_lock |= locked;
      for (int k = 1; k <= 10; k++) begin
        if (i == k * SW - 1) chk("walk_offset", 32'(offset), 32'(k % 10));
      end
    end
    chk("never_locked", 32'(seen_lock), 32'd0);

    // Reset pulse while locked, then relock from offset 0
    do_reset();
    for (int i = 0; i < 2 * LINE + 20; i++) feed(0, i % LINE);
    chk("pre_reset_locked", 32'(locked), 32'd1);
    do_reset();
    for (int i = 0; i < 2 * LINE + 20; i++) feed(0, i % LINE);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_offset", 32'(offset), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
